// File: rtl/chip_select_sequencer_pkg.sv
// Shared definitions for the chip select sequencer: VIC-II chip codes,
// sequencer state encoding and the counter sizing helper.
package chip_select_sequencer_pkg;

    localparam logic [1:0] CHIP6567R8   = 2'd0;
    localparam logic [1:0] CHIP6569     = 2'd1;
    localparam logic [1:0] CHIP6567R56A = 2'd2;
    localparam logic [1:0] CHIP6572     = 2'd3;

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    // One counter serves both the debounce and the reset hold, so it is sized for the longer.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/chip_select_sequencer_sync2.sv
// Two-flop synchroniser for asynchronous pins; both stages clear to 0 on srst.
module chip_select_sequencer_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] q_reg;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            always_ff @(posedge clk) begin
                if (srst) begin
                    meta_reg[gi] <= 1'b0;
                    q_reg[gi]    <= 1'b0;
                end else begin
                    meta_reg[gi] <= d[gi];
                    q_reg[gi]    <= meta_reg[gi];
                end
            end
        end
    endgenerate

    assign q = q_reg;

endmodule

// File: rtl/chip_select_sequencer.sv
// Debounces the video-standard switch, merges it with the configured chip model
// and sequences model changes with the 6510 held in reset around each change.
module chip_select_sequencer
    import chip_select_sequencer_pkg::*;
#(
    parameter int CHIP_W          = 2,
    parameter int RESET_CHIP      = int'(CHIP6567R8),
    parameter int DEBOUNCE_CYCLES = 2048,
    parameter int RESET_CYCLES    = 4096
) (
    input  logic              clk_dot4x,
    input  logic              rst,
    input  logic              standard_sw,
    input  logic [CHIP_W-1:0] cfg_chip,
    input  logic              sw_enable,
    output logic [CHIP_W-1:0] chip,
    output logic              clk_sel,
    output logic              cpu_reset,
    output logic              chip_change,
    output logic              busy
);

    localparam int                CNT_W      = cnt_width(DEBOUNCE_CYCLES, RESET_CYCLES);
    localparam logic [CNT_W-1:0]  DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  RST_LAST   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CHIP_W-1:0] RESET_CODE = CHIP_W'(RESET_CHIP);

    logic              sw_s;
    logic [CHIP_W-1:0] tgt;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [CHIP_W-1:0] pend_reg, pend_next;
    logic [CHIP_W-1:0] chip_reg, chip_next;
    logic              clk_sel_reg, clk_sel_next;
    logic              cpu_reset_reg, cpu_reset_next;
    logic              chip_change_reg, chip_change_next;
    logic              busy_reg, busy_next;

    chip_select_sequencer_sync2 #(.WIDTH(1)) u_sw_sync (
        .clk  (clk_dot4x),
        .srst (rst),
        .d    (standard_sw),
        .q    (sw_s)
    );

    // The switch, when enabled, only ever replaces the video-family bit.
    always_comb begin
        tgt = cfg_chip;
        if (sw_enable) begin
            tgt[0] = sw_s;
        end
    end

    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            state_reg       <= ST_HOLD;
            cnt_reg         <= '0;
            pend_reg        <= RESET_CODE;
            chip_reg        <= RESET_CODE;
            clk_sel_reg     <= RESET_CODE[0];
            cpu_reset_reg   <= 1'b1;
            chip_change_reg <= 1'b0;
            busy_reg        <= 1'b1;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            pend_reg        <= pend_next;
            chip_reg        <= chip_next;
            clk_sel_reg     <= clk_sel_next;
            cpu_reset_reg   <= cpu_reset_next;
            chip_change_reg <= chip_change_next;
            busy_reg        <= busy_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        pend_next        = pend_reg;
        chip_next        = chip_reg;
        clk_sel_next     = clk_sel_reg;
        cpu_reset_next   = cpu_reset_reg;
        chip_change_next = 1'b0;

        case (state_reg)
            ST_HOLD: begin
                cpu_reset_next = 1'b1;
                if (cnt_reg == RST_LAST) begin
                    state_next     = ST_RUN;
                    cnt_next       = '0;
                    cpu_reset_next = 1'b0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_RUN: begin
                cpu_reset_next = 1'b0;
                if (tgt != chip_reg) begin
                    state_next = ST_SETTLE;
                    cnt_next   = '0;
                    pend_next  = tgt;
                end
            end
            ST_SETTLE: begin
                if (tgt == chip_reg) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end else if (tgt != pend_reg) begin
                    pend_next = tgt;
                    cnt_next  = '0;
                end else if (cnt_reg == DEB_LAST) begin
                    // Clock family and CPU reset switch on the same edge so the mux glitch lands under reset.
                    chip_next        = pend_reg;
                    clk_sel_next     = pend_reg[0];
                    cpu_reset_next   = 1'b1;
                    chip_change_next = 1'b1;
                    state_next       = ST_HOLD;
                    cnt_next         = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next     = ST_HOLD;
                cnt_next       = '0;
                cpu_reset_next = 1'b1;
            end
        endcase

        busy_next = (state_next != ST_RUN);
    end

    assign chip        = chip_reg;
    assign clk_sel     = clk_sel_reg;
    assign cpu_reset   = cpu_reset_reg;
    assign chip_change = chip_change_reg;
    assign busy        = busy_reg;

endmodule
